// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified I/D memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating access watchdog: cleared outside ACCESS, counts ACCESS cycles,
// flags the cycle in which the access has lasted TIMEOUT_CYC cycles.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic hit
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W-1:0] count_inc;

  always_comb begin
    count_inc = count;
    if (count != '1) count_inc = count + TIMER_W'(1);
  end

  // Compared against the incremented value so mem_req stays high for exactly TIMEOUT_CYC cycles.
  assign hit = en && (count_inc == TIMER_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and load/store sides onto one memory port,
// sequences the handshake and returns data with a one-cycle ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  state_t        state;
  logic [SW-1:0] starve;
  logic          abandoned;
  logic          timer_hit;
  logic          owner_req;
  logic          pick_d;
  logic [31:0]   rsp_rdata;

  mem_arb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state != ACCESS),
    .en   (state == ACCESS),
    .hit  (timer_hit)
  );

  always_comb begin
    owner_req = (owner == OWNER_D) ? d_req : i_req;
    pick_d    = d_req && !(i_req && (starve == SW'(STARVE_MAX)));
    rsp_rdata = '0;
    if (mem_ready && (mem_we == '0)) rsp_rdata = mem_rdata;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      starve    <= '0;
      abandoned <= 1'b0;
      owner     <= OWNER_I;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state     <= ACCESS;
            mem_req   <= 1'b1;
            abandoned <= 1'b0;
            if (pick_d) begin
              owner     <= OWNER_D;
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
              if (i_req) starve <= starve + SW'(1);
            end else begin
              owner     <= OWNER_I;
              mem_addr  <= i_addr;
              mem_we    <= '0;
              mem_wdata <= '0;
              starve    <= '0;
            end
          end
        end
        ACCESS: begin
          // A requester that lets go mid-access still lets the memory finish, but gets no ack.
          if (!owner_req) abandoned <= 1'b1;
          if (mem_ready || timer_hit) begin
            state   <= ACK;
            mem_req <= 1'b0;
            if (owner_req && !abandoned) begin
              if (owner == OWNER_D) begin
                d_ack   <= 1'b1;
                d_rdata <= rsp_rdata;
                d_err   <= !mem_ready;
              end else begin
                i_ack   <= 1'b1;
                i_rdata <= rsp_rdata;
                i_err   <= !mem_ready;
              end
            end
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned SM = 4;
  localparam int unsigned TO = 8;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } dreq_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_we;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic        busy, owner;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  mem_port_arbiter #(
    .STARVE_MAX (SM),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_we     (d_we),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .busy     (busy),
    .owner    (owner)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return a ^ 32'hA5A5_0000;
  endfunction

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: answers ready_delay cycles into an access (first access cycle = 0).
  int ready_delay = 0;
  initial begin
    int acc_ct;
    acc_ct = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        mem_ready = (acc_ct == ready_delay);
        acc_ct++;
      end else begin
        mem_ready = 1'b0;
        acc_ct = 0;
      end
      mem_rdata = mem_ready ? mem_word(mem_addr) : '0;
    end
  end

  // Requesters: hold request until ack, then present the next queued one.
  logic [31:0] iq[$];
  dreq_t       dq[$];
  bit i_active = 0, d_active = 0;
  int i_pres_cyc = 0;
  int i_cancel_cnt = 0, flush_cnt = 0;

  initial begin
    int cancel_seen, iflush_seen;
    cancel_seen = 0;
    iflush_seen = 0;
    i_req = 1'b0;
    i_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (i_cancel_cnt != cancel_seen || flush_cnt != iflush_seen) begin
        cancel_seen = i_cancel_cnt;
        if (flush_cnt != iflush_seen) iq.delete();
        iflush_seen = flush_cnt;
        i_req = 1'b0;
        i_active = 0;
      end
      if (i_active && i_ack) begin
        i_active = 0;
        i_req = 1'b0;
      end
      if (!i_active && iq.size() > 0 && rst_n) begin
        i_addr = iq.pop_front();
        i_req = 1'b1;
        i_active = 1;
        i_pres_cyc = cyc;
      end
    end
  end

  initial begin
    int dflush_seen;
    dreq_t r;
    dflush_seen = 0;
    d_req = 1'b0;
    d_addr = '0;
    d_we = '0;
    d_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (flush_cnt != dflush_seen) begin
        dflush_seen = flush_cnt;
        dq.delete();
        d_req = 1'b0;
        d_active = 0;
      end
      if (d_active && d_ack) begin
        d_active = 0;
        d_req = 1'b0;
      end
      if (!d_active && dq.size() > 0 && rst_n) begin
        r = dq.pop_front();
        d_addr = r.addr;
        d_we = r.we;
        d_wdata = r.wdata;
        d_req = 1'b1;
        d_active = 1;
      end
    end
  end

  // Reference model: one transaction at a time, grant -> memory wait -> ack slot -> free.
  int          phase = 0;
  int          waited = 0;
  int          starve = 0;
  bit          gone = 0;
  logic        e_mem_req = 0, e_owner = 0, e_busy = 0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [3:0]  e_we = '0;
  logic        e_i_ack = 0, e_d_ack = 0, e_i_err = 0, e_d_err = 0;
  logic [31:0] e_i_rdata = '0, e_d_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; starve = 0; gone = 0; waited = 0;
      e_mem_req = 0; e_owner = 0; e_busy = 0;
      e_addr = '0; e_we = '0; e_wdata = '0;
      e_i_ack = 0; e_d_ack = 0; e_i_err = 0; e_d_err = 0;
      e_i_rdata = '0; e_d_rdata = '0;
    end else begin
      e_i_ack = 0;
      e_d_ack = 0;
      if (phase == 0) begin
        if (i_req || d_req) begin
          if (d_req && !(i_req && starve == SM)) begin
            e_owner = 1; e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
            if (i_req) starve = starve + 1;
          end else begin
            e_owner = 0; e_addr = i_addr; e_we = '0; e_wdata = '0;
            starve = 0;
          end
          phase = 1; waited = 0; gone = 0; e_mem_req = 1;
        end
      end else if (phase == 1) begin
        waited = waited + 1;
        if (!(e_owner ? d_req : i_req)) gone = 1;
        if (mem_ready || waited == TO) begin
          phase = 2;
          e_mem_req = 0;
          if (!gone) begin
            if (e_owner) begin
              e_d_ack = 1; e_d_err = !mem_ready;
              e_d_rdata = (mem_ready && e_we == 0) ? mem_rdata : 32'h0;
            end else begin
              e_i_ack = 1; e_i_err = !mem_ready;
              e_i_rdata = mem_ready ? mem_rdata : 32'h0;
            end
          end
        end
      end else begin
        phase = 0;
      end
      e_busy = (phase != 0);
    end
  end

  initial forever begin
    @(negedge clk);
    check("mem_req", {31'b0, mem_req}, {31'b0, e_mem_req});
    check("busy", {31'b0, busy}, {31'b0, e_busy});
    check("owner", {31'b0, owner}, {31'b0, e_owner});
    check("i_ack", {31'b0, i_ack}, {31'b0, e_i_ack});
    check("d_ack", {31'b0, d_ack}, {31'b0, e_d_ack});
    if (e_mem_req) begin
      check("mem_addr", mem_addr, e_addr);
      check("mem_we", {28'b0, mem_we}, {28'b0, e_we});
      check("mem_wdata", mem_wdata, e_wdata);
    end
    if (e_i_ack) begin
      check("i_rdata", i_rdata, e_i_rdata);
      check("i_err", {31'b0, i_err}, {31'b0, e_i_err});
    end
    if (e_d_ack) begin
      check("d_rdata", d_rdata, e_d_rdata);
      check("d_err", {31'b0, d_err}, {31'b0, e_d_err});
    end
  end

  // Observation log used by the literal expectations.
  int          i_acks = 0, d_acks = 0, i_ack_cyc = 0;
  logic [31:0] last_i_rdata = '0, last_d_rdata = '0;
  logic        last_i_err = 0, last_d_err = 0;
  int          run = 0, last_run = 0;
  logic        prev_mem_req = 0;
  logic        g_owner[$];
  logic [31:0] g_addr[$];
  logic [3:0]  g_we[$];
  logic [31:0] g_wdata[$];

  initial forever begin
    @(negedge clk);
    if (i_ack) begin
      i_acks++; i_ack_cyc = cyc; last_i_rdata = i_rdata; last_i_err = i_err;
    end
    if (d_ack) begin
      d_acks++; last_d_rdata = d_rdata; last_d_err = d_err;
    end
    if (mem_req && !prev_mem_req) begin
      g_owner.push_back(owner); g_addr.push_back(mem_addr);
      g_we.push_back(mem_we); g_wdata.push_back(mem_wdata);
    end
    if (mem_req) run++;
    else if (run > 0) begin
      last_run = run;
      run = 0;
    end
    prev_mem_req = mem_req;
  end

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #3;
      if (iq.size() == 0 && dq.size() == 0 && !i_active && !d_active && !busy) begin
        ok = 1;
        break;
      end
    end
    check({name, "_done"}, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    int base, ia, da;
    logic [6:0] order;
    bit seen;
    dreq_t r;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_owner", {31'b0, owner}, 32'd0);
    check("rst_acks", {30'b0, i_ack, d_ack}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", i_rdata | d_rdata, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fetch only, minimum latency.
    #2;
    ia = i_acks;
    ready_delay = 0;
    iq.push_back(32'h100);
    wait_idle("fetch", 20);
    check("fetch_acks", i_acks - ia, 1);
    check("fetch_latency", i_ack_cyc - i_pres_cyc, 2);
    check("fetch_rdata", last_i_rdata, 32'h13);
    check("fetch_err", {31'b0, last_i_err}, 32'd0);

    // Both request together: D first, then I.
    #2;
    base = g_owner.size();
    r.addr = 32'h200; r.we = 4'b0000; r.wdata = 32'h0;
    dq.push_back(r);
    iq.push_back(32'h104);
    wait_idle("both", 30);
    check("both_grants", g_owner.size() - base, 2);
    if (g_owner.size() - base == 2) begin
      check("both_first_owner", {31'b0, g_owner[base]}, 32'd1);
      check("both_first_addr", g_addr[base], 32'h200);
      check("both_second_owner", {31'b0, g_owner[base+1]}, 32'd0);
      check("both_second_addr", g_addr[base+1], 32'h104);
    end

    // Byte store with a slow memory.
    #2;
    base = g_owner.size();
    da = d_acks;
    ready_delay = 3;
    r.addr = 32'h300; r.we = 4'b0100; r.wdata = 32'h00AB_0000;
    dq.push_back(r);
    wait_idle("store", 30);
    check("store_acks", d_acks - da, 1);
    check("store_rdata", last_d_rdata, 32'h0);
    check("store_req_cycles", last_run, 4);
    if (g_owner.size() - base == 1) begin
      check("store_we", {28'b0, g_we[base]}, 32'h4);
      check("store_wdata", g_wdata[base], 32'h00AB_0000);
    end else check("store_grants", g_owner.size() - base, 1);

    // Starvation bound: I waits behind at most four D grants.
    #2;
    base = g_owner.size();
    ready_delay = 1;
    iq.push_back(32'h400);
    for (int k = 0; k < 6; k++) begin
      r.addr = 32'h500 + 32'(k * 4); r.we = 4'b0000; r.wdata = 32'h0;
      dq.push_back(r);
    end
    wait_idle("starve", 100);
    order = 7'b1101111;
    check("starve_grants", g_owner.size() - base, 7);
    if (g_owner.size() - base == 7)
      for (int k = 0; k < 7; k++)
        check($sformatf("starve_order%0d", k), {31'b0, g_owner[base+k]}, {31'b0, order[k]});

    // Memory never answers: watchdog abort.
    #2;
    da = d_acks;
    ready_delay = 1000;
    r.addr = 32'h600; r.we = 4'b0000; r.wdata = 32'h0;
    dq.push_back(r);
    wait_idle("timeout", 40);
    check("timeout_req_cycles", last_run, TO);
    check("timeout_acks", d_acks - da, 1);
    check("timeout_err", {31'b0, last_d_err}, 32'd1);
    check("timeout_rdata", last_d_rdata, 32'h0);

    // Fetch dropped mid-access: memory finishes, no ack.
    #2;
    ia = i_acks;
    ready_delay = 4;
    iq.push_back(32'h700);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk);
      #2;
      seen = mem_req;
    end
    check("drop_started", {31'b0, seen}, 32'd1);
    i_cancel_cnt++;
    wait_idle("drop", 30);
    check("drop_acks", i_acks - ia, 0);
    check("drop_req_cycles", last_run, 5);

    // Asynchronous reset in the middle of a data access.
    #2;
    da = d_acks;
    ready_delay = 1000;
    r.addr = 32'h800; r.we = 4'b0000; r.wdata = 32'h0;
    dq.push_back(r);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk);
      #2;
      seen = mem_req;
    end
    check("arst_started", {31'b0, seen}, 32'd1);
    check("arst_owner_before", {31'b0, owner}, 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    flush_cnt++;
    #1;
    check("arst_mem_req", {31'b0, mem_req}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    check("arst_idle", {31'b0, busy}, 32'd0);
    check("arst_owner", {31'b0, owner}, 32'd0);
    check("arst_no_ack", d_acks - da, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
